audio_dac: RTL and testbench
============================

AUDIO_DAC -- requirements
Module: audio_dac

Interface
REQ-001 Parameter SHIFT, default 0: arithmetic right-shift applied to the incoming sample before clamping.
REQ-002 Parameter RES_W, default 10: output resolution in bits; PWM period is 2^RES_W clocks.
REQ-003 Port clk_i, input, 1: system clock (50 MHz); single clock domain.
REQ-004 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 Port audio_valid_i, input, 1: one-cycle strobe qualifying audio_i.
REQ-006 Port audio_i, input, 16: signed two's-complement mixed sample from the controller.
REQ-007 Port mode_i, input, 1: 0 = PWM, 1 = first-order delta-sigma.
REQ-008 Port ovr_clr_i, input, 1: clears the sticky overrun flag.
REQ-009 Port dac_o, input-free output, 1: registered 1-bit DAC bitstream to the pin.
REQ-010 Port level_o, output, RES_W: active unsigned duty value.
REQ-011 Port period_o, output, 1: one-cycle pulse on the first cycle of each period (cnt = 0).
REQ-012 Port overrun_o, output, 1: sticky flag; a sample was overwritten before use.

Function
REQ-013 Conversion: s = audio_i >>> SHIFT; clamp to [-2^(RES_W-1), 2^(RES_W-1)-1]; add 2^(RES_W-1) to give an unsigned code u (0..1023 by default).
REQ-014 Conversion is registered into pending on the audio_valid_i cycle; pending_full is set.
REQ-015 A free-running RES_W-bit counter cnt increments every clock, wraps 1023 -> 0.
REQ-016 At cnt = 1023 (wrap cycle): if pending_full, active <= pending and pending_full is cleared; otherwise active holds.
REQ-017 Valid on the wrap cycle: the transfer uses the old pending value; the new sample lands in pending and pending_full stays set.
REQ-018 Valid while pending_full is set (and not on a wrap cycle that consumes it): overwrite pending (newest wins), set overrun_o.
REQ-019 ovr_clr_i clears overrun_o; a simultaneous overrun event takes priority (flag stays set).
REQ-020 PWM mode: dac_o <= (cnt < active); active 0 yields constant low, 1023 yields high 1023 of 1024 cycles.
REQ-021 Delta-sigma mode: {carry, acc} <= acc + active each clock (RES_W+1 bits); dac_o <= carry.
REQ-022 mode_i is sampled only on the wrap cycle; on a mode change, acc is cleared to 0.
REQ-023 level_o = active; period_o is registered, high when cnt = 0.
REQ-024 Sample latency: a sample is visible on level_o at most one full period + 1 clock after its strobe.

Reset
REQ-025 On rst_ni low: cnt = 0, acc = 0, pending = active = 512 (midscale, no pop), pending_full = 0, mode = PWM, dac_o = 0, period_o = 0, overrun_o = 0.
REQ-026 Reset mid-period takes effect asynchronously; after release, cnt restarts at 0 and the first period_o pulse appears 1024 clocks later.

Structure
REQ-027 Shared package tt6581_pkg holds RES_W default, the audio sample typedef (signed 16-bit), and the dac mode enum (DAC_PWM, DAC_DSM).
REQ-028 One sub-module, sample_clamp (combinational shift, saturate, offset), is natural; all state stays in audio_dac.
REQ-029 audio_dac replaces the direct wave = mix_out[9:0] tap at the top level, driven by the controller's audio_valid/audio outputs.

Verification
REQ-030 Strobe audio_i = 0x0000 at cnt = 100, PWM -> from the next period, level_o = 512 and dac_o is high for exactly 512 of 1024 cycles.
REQ-031 Strobe 0x7FFF, then 0x8000 one period later, SHIFT = 0 -> level_o = 1023 (high 1023/1024), then 0 (dac_o constant low).
REQ-032 Two strobes, 0x0010 then 0x0020, in one period -> overrun_o = 1, next level_o = 544; ovr_clr_i pulse -> overrun_o = 0.
REQ-033 Strobe 0x0100 exactly at cnt = 1023 with pending = 600 -> level_o = 600 this period, 768 next period, no overrun.
REQ-034 mode_i = 1, active = 256 -> dac_o averages 256/1024 over every 1024-cycle window, with ones spaced every 4 clocks.
REQ-035 Assert rst_ni low at cnt = 500 with active = 900 -> dac_o = 0 and level_o = 512 immediately; period_o is first seen 1024 clocks after release.

Source files
------------

// File: rtl/tt6581_pkg.sv
// Shared types for the tt6581 audio path: resolution default, sample type and DAC mode.
package tt6581_pkg;

    localparam int DAC_RES_W = 10;

    typedef logic signed [15:0] audio_t;

    typedef enum logic {
        DAC_PWM = 1'b0,
        DAC_DSM = 1'b1
    } dac_mode_e;

endpackage

// File: rtl/sample_clamp.sv
// Combinational sample conditioning: arithmetic shift, saturation to RES_W signed bits,
// and offset to an unsigned duty code.
module sample_clamp
    import tt6581_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int RES_W = DAC_RES_W
) (
    input  audio_t            i_audio,
    output logic [RES_W-1:0]  o_code
);

    localparam audio_t MAX_C = audio_t'((1 << (RES_W - 1)) - 1);
    localparam audio_t MIN_C = audio_t'(-(1 << (RES_W - 1)));

    audio_t w_shift;
    audio_t w_sat;

    assign w_shift = i_audio >>> SHIFT;

    always_comb begin
        w_sat = w_shift;
        if (w_shift > MAX_C) begin
            w_sat = MAX_C;
        end else if (w_shift < MIN_C) begin
            w_sat = MIN_C;
        end else begin
            w_sat = w_shift;
        end
    end

    // Adding midscale to an in-range two's-complement value is a sign-bit flip.
    assign o_code = {~w_sat[RES_W-1], w_sat[RES_W-2:0]};

endmodule

// File: rtl/audio_dac.sv
// 1-bit audio DAC: double-buffered sample, PWM or first-order delta-sigma bitstream,
// sample swap and mode change only at the period wrap.
module audio_dac
    import tt6581_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int RES_W = DAC_RES_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              audio_valid_i,
    input  audio_t            audio_i,
    input  logic              mode_i,
    input  logic              ovr_clr_i,
    output logic              dac_o,
    output logic [RES_W-1:0]  level_o,
    output logic              period_o,
    output logic              overrun_o
);

    localparam logic [RES_W-1:0] MID_C     = {1'b1, {(RES_W-1){1'b0}}};
    localparam logic [RES_W-1:0] CNT_MAX_C = {RES_W{1'b1}};
    localparam logic [RES_W-1:0] ZERO_C    = {RES_W{1'b0}};

    logic [RES_W-1:0] r_cnt;
    logic [RES_W-1:0] r_pending;
    logic             r_pending_full;
    logic [RES_W-1:0] r_active;
    logic [RES_W-1:0] r_acc;
    dac_mode_e        r_mode;
    logic             r_dac;
    logic             r_period;
    logic             r_overrun;

    logic [RES_W-1:0] w_code;
    logic [RES_W:0]   w_sum;
    logic             w_wrap;
    logic             w_ovr_evt;
    logic             w_mode_chg;
    logic             w_dac_nxt;
    dac_mode_e        w_mode_in;

    sample_clamp #(
        .SHIFT (SHIFT),
        .RES_W (RES_W)
    ) u_clamp (
        .i_audio (audio_i),
        .o_code  (w_code)
    );

    assign w_wrap     = (r_cnt == CNT_MAX_C);
    assign w_mode_in  = mode_i ? DAC_DSM : DAC_PWM;
    assign w_mode_chg = w_wrap && (w_mode_in != r_mode);
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_active};
    // A wrap that consumes pending makes room, so a strobe there is not an overrun.
    assign w_ovr_evt  = audio_valid_i && r_pending_full && !w_wrap;

    always_comb begin
        w_dac_nxt = 1'b0;
        case (r_mode)
            DAC_PWM: w_dac_nxt = (r_cnt < r_active);
            DAC_DSM: w_dac_nxt = w_sum[RES_W];
            default: w_dac_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= ZERO_C;
            r_period <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_period <= w_wrap;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending      <= MID_C;
            r_pending_full <= 1'b0;
            r_active       <= MID_C;
        end else begin
            if (audio_valid_i) begin
                r_pending <= w_code;
            end
            if (audio_valid_i) begin
                r_pending_full <= 1'b1;
            end else if (w_wrap) begin
                r_pending_full <= 1'b0;
            end
            if (w_wrap && r_pending_full) begin
                r_active <= r_pending;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode <= DAC_PWM;
            r_acc  <= ZERO_C;
            r_dac  <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_mode <= w_mode_in;
            end
            if (w_mode_chg) begin
                r_acc <= ZERO_C;
            end else begin
                r_acc <= w_sum[RES_W-1:0];
            end
            r_dac <= w_dac_nxt;
        end
    end

    // A fresh overrun wins over a simultaneous clear request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_evt) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr_i) begin
            r_overrun <= 1'b0;
        end
    end

    assign dac_o     = r_dac;
    assign level_o   = r_active;
    assign period_o  = r_period;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_audio_dac.sv
// Directed self-checking bench for audio_dac with default parameters (SHIFT=0, RES_W=10).
module tb_audio_dac;

    logic               clk;
    logic               rst_n;
    logic               audio_valid;
    logic signed [15:0] audio;
    logic               mode;
    logic               ovr_clr;
    logic               dac;
    logic [9:0]         level;
    logic               period;
    logic               overrun;

    int n_checks;
    int n_fail;
    int tb_cnt;

    audio_dac dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .audio_valid_i (audio_valid),
        .audio_i       (audio),
        .mode_i        (mode),
        .ovr_clr_i     (ovr_clr),
        .dac_o         (dac),
        .level_o       (level),
        .period_o      (period),
        .overrun_o     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        tb_cnt = (tb_cnt + 1) % 1024;
    endtask

    // Tick at least once, stopping when the counter model reaches target.
    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (tb_cnt != target && n < 1100);
    endtask

    task automatic strobe(input logic [15:0] val);
        audio_valid = 1'b1;
        audio       = val;
        tick();
        audio_valid = 1'b0;
    endtask

    // Count dac highs over 1024 edges; optionally strobe a sample on the first edge.
    task automatic count_period(input bit do_strobe, input logic [15:0] val, output int ones);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 0 && do_strobe) begin
                audio_valid = 1'b1;
                audio       = val;
            end
            tick();
            audio_valid = 1'b0;
            if (dac === 1'b1) ones++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; audio_valid = 1'b0; audio = 16'sd0; mode = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        tb_cnt = 0;
        n_checks++; if (level !== 10'd512) begin n_fail++; $display("FAIL reset_level: got %0d expected 512", level); end
        n_checks++; if (dac !== 1'b0) begin n_fail++; $display("FAIL reset_dac: got %0b expected 0", dac); end
        n_checks++; if (period !== 1'b0) begin n_fail++; $display("FAIL reset_period: got %0b expected 0", period); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    endtask

    task automatic test_midscale();
        int ones;
        wait_cnt(100);
        strobe(16'h0000);
        wait_cnt(0);
        n_checks++; if (period !== 1'b1) begin n_fail++; $display("FAIL mid_period_pulse: got %0b expected 1", period); end
        n_checks++; if (level !== 10'd512) begin n_fail++; $display("FAIL mid_level: got %0d expected 512", level); end
        count_period(1'b0, 16'h0000, ones);
        n_checks++; if (ones !== 512) begin n_fail++; $display("FAIL mid_duty: got %0d expected 512", ones); end
    endtask

    task automatic test_extremes();
        int ones;
        wait_cnt(10);
        strobe(16'h7FFF);
        wait_cnt(0);
        n_checks++; if (level !== 10'd1023) begin n_fail++; $display("FAIL max_level: got %0d expected 1023", level); end
        count_period(1'b1, 16'h8000, ones);
        n_checks++; if (ones !== 1023) begin n_fail++; $display("FAIL max_duty: got %0d expected 1023", ones); end
        n_checks++; if (level !== 10'd0) begin n_fail++; $display("FAIL min_level: got %0d expected 0", level); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL min_no_overrun: got %0b expected 0", overrun); end
        count_period(1'b0, 16'h0000, ones);
        n_checks++; if (ones !== 0) begin n_fail++; $display("FAIL min_duty: got %0d expected 0", ones); end
    endtask

    task automatic test_overrun();
        wait_cnt(20);
        strobe(16'h0010);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_strobe: got %0b expected 0", overrun); end
        wait_cnt(40);
        strobe(16'h0020);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %0b expected 1", overrun); end
        wait_cnt(0);
        n_checks++; if (level !== 10'd544) begin n_fail++; $display("FAIL ovr_newest_wins: got %0d expected 544", level); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %0b expected 0", overrun); end
    endtask

    task automatic test_wrap_strobe();
        wait_cnt(300);
        strobe(16'h0058);
        wait_cnt(1023);
        strobe(16'h0100);
        n_checks++; if (level !== 10'd600) begin n_fail++; $display("FAIL wrap_old_pending: got %0d expected 600", level); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL wrap_no_overrun: got %0b expected 0", overrun); end
        wait_cnt(0);
        n_checks++; if (level !== 10'd768) begin n_fail++; $display("FAIL wrap_new_sample: got %0d expected 768", level); end
    endtask

    task automatic test_dsm();
        int ones;
        int misplaced;
        wait_cnt(5);
        strobe(16'hFF00);
        mode = 1'b1;
        wait_cnt(0);
        n_checks++; if (level !== 10'd256) begin n_fail++; $display("FAIL dsm_level: got %0d expected 256", level); end
        ones = 0;
        misplaced = 0;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            if (dac === 1'b1) begin
                ones++;
                if (i % 4 != 0) misplaced++;
            end
        end
        n_checks++; if (ones !== 256) begin n_fail++; $display("FAIL dsm_density: got %0d expected 256", ones); end
        n_checks++; if (misplaced !== 0) begin n_fail++; $display("FAIL dsm_spacing: got %0d off-grid ones expected 0", misplaced); end
        mode = 1'b0;
        wait_cnt(0);
    endtask

    task automatic test_reset_mid();
        int early;
        wait_cnt(7);
        strobe(16'h0184);
        wait_cnt(0);
        n_checks++; if (level !== 10'd900) begin n_fail++; $display("FAIL rst_pre_level: got %0d expected 900", level); end
        wait_cnt(500);
        n_checks++; if (dac !== 1'b1) begin n_fail++; $display("FAIL rst_pre_dac: got %0b expected 1", dac); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dac !== 1'b0) begin n_fail++; $display("FAIL rst_async_dac: got %0b expected 0", dac); end
        n_checks++; if (level !== 10'd512) begin n_fail++; $display("FAIL rst_async_level: got %0d expected 512", level); end
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        tb_cnt = 0;
        early  = 0;
        for (int i = 1; i < 1024; i++) begin
            tick();
            if (period === 1'b1) early++;
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL rst_no_early_period: got %0d pulses expected 0", early); end
        tick();
        n_checks++; if (period !== 1'b1) begin n_fail++; $display("FAIL rst_first_period: got %0b expected 1", period); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tb_cnt   = 0;
        test_reset();
        test_midscale();
        test_extremes();
        test_overrun();
        test_wrap_strobe();
        test_dsm();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
